// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath bundle between aes_round_ctrl (master) and its
// surroundings: input FIFO, round datapath, key unit and ciphertext consumer.
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   in_mode;

    logic [127:0] dp_state;
    logic [4:0]   dp_round;
    logic [1:0]   dp_mode;
    logic [127:0] dp_result;

    logic         rk_req;
    logic         rk_valid;

    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        input  in_valid, in_data, in_mode, dp_result, rk_valid, out_ready,
        output in_ready, dp_state, dp_round, dp_mode, rk_req, out_valid,
               out_data, busy
    );

    modport slave (
        output in_valid, in_data, in_mode, dp_result, rk_valid, out_ready,
        input  in_ready, dp_state, dp_round, dp_mode, rk_req, out_valid,
               out_data, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath.
// Defining AES_ROUND_CTRL_ABORT_EN adds an abort input that drops RUN/DONE back to IDLE.
module aes_round_ctrl (
    input  logic clk,
    input  logic rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic abort,
`endif
    aes_round_ctrl_if.master bus
);
    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // RUN   | commits one round per cycle in which rk_valid is high
    // DONE  | ciphertext presented on out_data until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] ROUND_WHITEN = 5'd2;

    state_t       state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [4:0]   round_q, round_d;
    logic [1:0]   mode_q, mode_d;
    logic [4:0]   final_round;
    logic         last_round;
    logic         abort_req;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        final_round = 5'd12;
        case (mode_q)
            2'h2:    final_round = 5'd14;
            2'h3:    final_round = 5'd16;
            default: final_round = 5'd12;
        endcase
    end

    // >= rather than == so a corrupted index can never run past the last round
    assign last_round = (round_q >= final_round);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            round_q <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        round_d       = round_q;
        mode_d        = mode_q;
        bus.in_ready  = 1'b0;
        bus.rk_req    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    blk_d   = bus.in_data;
                    mode_d  = bus.in_mode;
                    round_d = ROUND_WHITEN;
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.rk_req = 1'b1;
                bus.busy   = 1'b1;
                if (abort_req) begin
                    state_d = IDLE;
                end else if (bus.rk_valid) begin
                    blk_d = bus.dp_result;
                    if (last_round) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 5'd1;
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (abort_req || bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dp_state = blk_q;
    assign bus.out_data = blk_q;
    assign bus.dp_round = round_q;
    assign bus.dp_mode  = mode_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: models the round datapath and key unit, and
// checks the controller against a block-level model every cycle.
module tb_aes_round_ctrl;
    logic clk;
    logic rst;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic abort;
`endif

    aes_round_ctrl_if bus ();

    aes_round_ctrl dut (
        .clk  (clk),
        .rst  (rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] rk [0:14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within the cycle budget", name);
    endtask

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            b   = 8'(v);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gm(inv, b);
            if (b == 8'h00) inv = 8'h00;
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127 - 8*(4*c + w) -: 8] = sb[s[127 - 8*(4*((c + w) % 4) + w) -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic int nr_of(input logic [1:0] m);
        return (m == 2'h2) ? 12 : (m == 2'h3) ? 14 : 10;
    endfunction

    task automatic load_keys(input logic [255:0] key, input logic [1:0] m);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr, nk;
        nr = nr_of(m);
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < nr; r++) s = mix(sub_shift(s)) ^ rk[r];
        return sub_shift(s) ^ rk[nr];
    endfunction

    // Combinational round datapath seen by the controller
    function automatic logic [127:0] dp_fn(input logic [127:0] s, input logic [4:0] round,
                                           input logic [1:0] mode);
        int r, fin;
        r   = int'(round);
        fin = nr_of(mode) + 2;
        if (r < 2 || r > fin) return s;
        if (r == 2) return s ^ rk[0];
        if (r == fin) return sub_shift(s) ^ rk[r-2];
        return mix(sub_shift(s)) ^ rk[r-2];
    endfunction

    always_comb bus.dp_result = dp_fn(bus.dp_state, bus.dp_round, bus.dp_mode);

    // ---------------- block-level model ----------------
    logic         m_active;
    int           m_commits;
    int           m_nr;
    logic [1:0]   m_mode;
    logic [127:0] m_ct;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_commits <= 0;
            m_nr      <= 10;
            m_mode    <= 2'h0;
            m_ct      <= '0;
        end else if (m_active) begin
`ifdef AES_ROUND_CTRL_ABORT_EN
            if (abort) m_active <= 1'b0; else
`endif
            if (m_commits == m_nr + 1) begin
                if (bus.out_ready) m_active <= 1'b0;
            end else if (bus.rk_valid) begin
                m_commits <= m_commits + 1;
            end
        end else if (bus.in_valid) begin
            m_active  <= 1'b1;
            m_commits <= 0;
            m_nr      <= nr_of(bus.in_mode);
            m_mode    <= bus.in_mode;
            m_ct      <= aes_enc(bus.in_data, nr_of(bus.in_mode));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 128'(bus.busy), 128'(m_active));
            check("in_ready", 128'(bus.in_ready), 128'(!m_active));
            check("rk_req", 128'(bus.rk_req), 128'(m_active && m_commits <= m_nr));
            check("out_valid", 128'(bus.out_valid), 128'(m_active && m_commits == m_nr + 1));
            if (m_active) begin
                check("dp_round", 128'(bus.dp_round),
                      128'(2 + ((m_commits < m_nr) ? m_commits : m_nr)));
                check("dp_mode", 128'(bus.dp_mode), 128'(m_mode));
                if (m_commits == m_nr + 1) check("out_data", bus.out_data, m_ct);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic check_reset(input string tag);
        check({tag, "_dp_state"}, bus.dp_state, 128'h0);
        check({tag, "_dp_round"}, 128'(bus.dp_round), 128'h0);
        check({tag, "_dp_mode"}, 128'(bus.dp_mode), 128'h0);
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'h0);
        check({tag, "_rk_req"}, 128'(bus.rk_req), 128'h0);
        check({tag, "_busy"}, 128'(bus.busy), 128'h0);
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'h1);
    endtask

    task automatic start_block(input logic [1:0] mode, input logic [255:0] key,
                               input logic [127:0] pt, input logic [1:0] alt_mode);
        int n;
        load_keys(key, mode);
        bus.in_data  = pt;
        bus.in_mode  = mode;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) fail_bound("accept_timeout");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_mode  = alt_mode;
    endtask

    task automatic wait_round(input int r);
        int n;
        n = 0;
        while (int'(bus.dp_round) != r && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (int'(bus.dp_round) != r) fail_bound("wait_round_timeout");
    endtask

    task automatic finish_block(input int stall_at, input int stall_n, input int hold_n,
                                output int lat, output logic [127:0] ct);
        logic [127:0] held;
        int left;
        left = stall_n;
        lat  = 0;
        while (!bus.out_valid && lat < 100) begin
            if (left > 0 && int'(bus.dp_round) == stall_at) begin
                bus.rk_valid = 1'b0;
                held = bus.dp_state;
                for (int i = 0; i < left; i++) begin
                    @(posedge clk); #1; lat++;
                    check("stall_round", 128'(bus.dp_round), 128'(stall_at));
                    check("stall_state", bus.dp_state, held);
                    check("stall_rk_req", 128'(bus.rk_req), 128'h1);
                end
                bus.rk_valid = 1'b1;
                left = 0;
            end else begin
                @(posedge clk); #1; lat++;
            end
        end
        if (!bus.out_valid) fail_bound("out_valid_timeout");
        ct = bus.out_data;
        if (hold_n > 0) begin
            bus.out_ready = 1'b0;
            bus.in_data   = ~ct;
            bus.in_valid  = 1'b1;
            for (int i = 0; i < hold_n; i++) begin
                @(posedge clk); #1;
                check("hold_out_valid", 128'(bus.out_valid), 128'h1);
                check("hold_out_data", bus.out_data, ct);
                check("hold_in_ready", 128'(bus.in_ready), 128'h0);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("xfer_out_valid", 128'(bus.out_valid), 128'h0);
        check("xfer_busy", 128'(bus.busy), 128'h0);
        bus.in_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [127:0] ct;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'h0;
        bus.rk_valid  = 1'b1;
        bus.out_ready = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        init_sbox();
        load_keys(KEY128, 2'h0);
        #3;
        check_reset("por");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        start_block(2'h0, KEY128, PT, 2'h2);
        finish_block(0, 0, 0, lat, ct);
        check("lat_mode0", 128'(lat), 128'd11);
        check("ct_mode0", ct, CT128);

        start_block(2'h1, KEY128, PT, 2'h3);
        finish_block(0, 0, 0, lat, ct);
        check("lat_mode1", 128'(lat), 128'd11);
        check("ct_mode1", ct, CT128);

        start_block(2'h2, KEY192, PT, 2'h0);
        finish_block(0, 0, 0, lat, ct);
        check("lat_mode2", 128'(lat), 128'd13);
        check("ct_mode2", ct, CT192);

        start_block(2'h3, KEY256, PT, 2'h1);
        finish_block(0, 0, 0, lat, ct);
        check("lat_mode3", 128'(lat), 128'd15);
        check("ct_mode3", ct, CT256);

        start_block(2'h0, KEYB, PTB, 2'h0);
        finish_block(7, 3, 0, lat, ct);
        check("lat_stall", 128'(lat), 128'd14);
        check("ct_stall", ct, CTB);

        start_block(2'h3, KEY256, PT, 2'h3);
        finish_block(0, 0, 5, lat, ct);
        check("lat_hold", 128'(lat), 128'd15);
        check("ct_hold", ct, CT256);

        start_block(2'h0, KEY128, PT, 2'h0);
        wait_round(9);
        #2 rst = 1'b1;
        #1 check_reset("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_block(2'h0, KEY128, PT, 2'h0);
        finish_block(0, 0, 0, lat, ct);
        check("lat_after_rst", 128'(lat), 128'd11);
        check("ct_after_rst", ct, CT128);

`ifdef AES_ROUND_CTRL_ABORT_EN
        start_block(2'h2, KEY192, PT, 2'h2);
        wait_round(5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 128'(bus.busy), 128'h0);
        check("abort_in_ready", 128'(bus.in_ready), 128'h1);
        check("abort_out_valid", 128'(bus.out_valid), 128'h0);
        repeat (20) @(posedge clk);
        #1;
        abort = 1'b1;
        start_block(2'h0, KEY128, PT, 2'h0);
        abort = 1'b0;
        check("abort_idle_accept", 128'(bus.busy), 128'h1);
        finish_block(0, 0, 0, lat, ct);
        check("lat_after_abort", 128'(lat), 128'd11);
        check("ct_after_abort", ct, CT128);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
